kbd_cmd_queue: RTL



---
 rtl/kbd_cmd_queue_if.sv | 20 ++
 rtl/kbd_cmd_queue.sv | 115 +++++++++++
 2 files changed

// File: rtl/kbd_cmd_queue_if.sv
// rtl/kbd_cmd_queue_if.sv - key event and PicoBlaze input-port bus between receiver, queue and CPU
interface kbd_cmd_queue_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] rd_data;
  logic       cmd_pending;

  modport master (
    output key_code, key_valid, port_id, read_strobe,
    input  key_ack, rd_data, cmd_pending
  );

  modport slave (
    input  key_code, key_valid, port_id, read_strobe,
    output key_ack, rd_data, cmd_pending
  );
endinterface

// File: rtl/kbd_cmd_queue.sv
// rtl/kbd_cmd_queue.sv - PS/2 key to command decoder with small FIFO read by the PicoBlaze
module kbd_cmd_queue #(
  parameter int         DEPTH_LOG2  = 2,
  parameter logic [7:0] PORT_DATA   = 8'h0A,
  parameter logic [7:0] PORT_STATUS = 8'h0B
) (
  input logic            clk,
  input logic            reset,
  kbd_cmd_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;

  state_t                state_q, state_d;
  logic [3:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q, tail_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic                  key_ack_q;
  logic                  cmd_pending_q;

  logic       attempt;
  logic       dec_valid;
  logic [3:0] dec_cmd;
  logic       empty, full;
  logic       pop, push, ovf_set, status_rd;
  logic [2:0] count_lo;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign count_lo = 3'(count_q);

  // Translate the scan code into a command; zero means the key is not one we act on.
  always_comb begin
    dec_valid = 1'b1;
    dec_cmd   = 4'h0;
    case (bus.key_code)
      8'h2B:   dec_cmd = 4'h1;
      8'h33:   dec_cmd = 4'h2;
      8'h2C:   dec_cmd = 4'h3;
      8'h75:   dec_cmd = 4'h4;
      8'h74:   dec_cmd = 4'h5;
      8'h6B:   dec_cmd = 4'h6;
      8'h72:   dec_cmd = 4'h7;
      8'h76:   dec_cmd = 4'h8;
      default: dec_valid = 1'b0;
    endcase
  end

  // One push attempt per key_valid episode: sample in IDLE, ack, then wait for the flag to clear.
  always_comb begin
    state_d = state_q;
    attempt = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          attempt = 1'b1;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_CLR;
      WAIT_CLR: if (!bus.key_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // A pop frees the head slot in the same edge, so a full FIFO can still take a push then.
  assign pop       = bus.read_strobe && (bus.port_id == PORT_DATA) && !empty;
  assign status_rd = bus.read_strobe && (bus.port_id == PORT_STATUS);
  assign push      = attempt && dec_valid && (!full || pop);
  assign ovf_set   = attempt && dec_valid && full && !pop;

  // Capture state, FIFO pointers/count, sticky overflow and the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      key_ack_q     <= 1'b0;
      cmd_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_ack_q     <= (state_q == ACK);
      cmd_pending_q <= !empty;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (ovf_set)        overflow_q <= 1'b1;
      else if (status_rd) overflow_q <= 1'b0;
    end
  end

  // Command storage; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= dec_cmd;
  end

  // Input-port mux seen by the PicoBlaze.
  always_comb begin
    bus.rd_data = 8'h00;
    if (bus.port_id == PORT_DATA) begin
      if (!empty) bus.rd_data = {4'h0, mem[head_q]};
    end else if (bus.port_id == PORT_STATUS) begin
      bus.rd_data = {overflow_q, empty, full, 2'b00, count_lo};
    end
  end

  assign bus.key_ack     = key_ack_q;
  assign bus.cmd_pending = cmd_pending_q;
endmodule
